// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver with a configurable frame format, parity and framing checks,
//   break detection, and a small first-word-fall-through output FIFO with a
//   valid/ready handshake. Each bit is decided by a 3-sample majority vote
//   around mid-bit.
//
// Ports
//   i_Clock       system clock
//   i_Reset       asynchronous, active-high reset
//   i_RX_Serial   asynchronous serial line, idle high
//   o_RX_Valid    FIFO head is valid
//   i_RX_Ready    consumer takes the head when o_RX_Valid && i_RX_Ready
//   o_RX_Data     FIFO head data, LSB = first received bit
//   o_Parity_Err  FIFO head parity error flag
//   o_Frame_Err   FIFO head framing error flag
//   o_Overrun     1-cycle pulse, a frame was dropped because the FIFO was full
//   o_Break       1-cycle pulse, break condition detected
//   o_Busy        receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_Valid,
  input  logic                 i_RX_Ready,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam logic [15:0] MID       = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int          ENTRY_W   = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------- receiver
  logic                 rx_meta_reg, rx_sync_reg, rx;
  state_t               state_reg, state_next;
  logic [15:0]          cnt_reg, cnt_next;
  logic [1:0]           samp_reg, samp_next;
  logic [3:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 stop0_low_reg, stop0_low_next;
  logic                 vote, at_vote, data_xor, par_err;
  logic                 commit_ferr, commit_first_low, is_break;
  logic                 push, brk_det;
  logic [ENTRY_W-1:0]   push_entry;

  assign rx      = rx_sync_reg;
  assign at_vote = (cnt_reg == MID + 16'd1);
  // Two samples were stored at MID-1 and MID; the live line is the third.
  assign vote    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx) | (samp_reg[1] & rx);

  assign data_xor = (^shift_reg) ^ par_bit_reg;
  assign par_err  = (PARITY == 1) ? ~data_xor : ((PARITY == 2) ? data_xor : 1'b0);
  // Only meaningful on the vote cycle of a stop bit.
  assign commit_ferr      = frame_err_reg | ~vote;
  assign commit_first_low = (stop_idx_reg == 1'b0) ? ~vote : stop0_low_reg;
  assign is_break         = (shift_reg == '0) && ((PARITY == 0) || !par_bit_reg) && commit_first_low;
  assign push_entry       = {par_err, commit_ferr, shift_reg};

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta_reg   <= 1'b1;
      rx_sync_reg   <= 1'b1;
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      samp_reg      <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      par_bit_reg   <= 1'b0;
      stop_idx_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      stop0_low_reg <= 1'b0;
    end else begin
      rx_meta_reg   <= i_RX_Serial;
      rx_sync_reg   <= rx_meta_reg;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      samp_reg      <= samp_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      par_bit_reg   <= par_bit_next;
      stop_idx_reg  <= stop_idx_next;
      frame_err_reg <= frame_err_next;
      stop0_low_reg <= stop0_low_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = (cnt_reg == LAST_CNT) ? 16'd0 : cnt_reg + 16'd1;
    samp_next      = samp_reg;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    par_bit_next   = par_bit_reg;
    stop_idx_next  = stop_idx_reg;
    frame_err_next = frame_err_reg;
    stop0_low_next = stop0_low_reg;
    push           = 1'b0;
    brk_det        = 1'b0;

    if (cnt_reg == MID - 16'd1) samp_next[0] = rx;
    if (cnt_reg == MID)         samp_next[1] = rx;

    case (state_reg)
      S_IDLE: begin
        cnt_next = 16'd0;
        if (!rx) begin
          // The cycle the low level is first seen is count 0 of the start bit.
          state_next     = S_START;
          cnt_next       = 16'd1;
          bit_idx_next   = '0;
          par_bit_next   = 1'b0;
          stop_idx_next  = 1'b0;
          frame_err_next = 1'b0;
          stop0_low_next = 1'b0;
        end
      end
      S_START: begin
        if (at_vote) state_next = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (at_vote) begin
          shift_next   = {vote, shift_reg[DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + 4'd1;
          if (bit_idx_reg == LAST_BIT) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (at_vote) begin
          par_bit_next = vote;
          state_next   = S_STOP;
        end
      end
      S_STOP: begin
        if (at_vote) begin
          if (stop_idx_reg == LAST_STOP) begin
            // Commit at mid-stop so back-to-back frames are never missed.
            if (is_break) begin
              brk_det    = 1'b1;
              state_next = S_WAIT_HIGH;
            end else begin
              push       = 1'b1;
              state_next = commit_ferr ? S_WAIT_HIGH : S_IDLE;
            end
          end else begin
            frame_err_next = commit_ferr;
            stop0_low_next = commit_first_low;
            stop_idx_next  = stop_idx_reg + 1'b1;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_next = 16'd0;
        if (rx) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------- FIFO
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               pop, push_ok;
  logic               overrun_reg, break_reg;
  logic [ENTRY_W-1:0] mem_rd [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop     = (count_reg != '0) && i_RX_Ready;
  assign push_ok = push && ((count_reg != CNT_W'(FIFO_DEPTH)) || pop);

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop)      count_next = count_reg + CNT_W'(1);
    else if (!push_ok && pop) count_next = count_reg - CNT_W'(1);
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      logic [ENTRY_W-1:0] slot_reg;
      always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)                                          slot_reg <= '0;
        else if (push_ok && (wr_ptr_reg == PTR_W'(gi)))       slot_reg <= push_entry;
      end
      assign mem_rd[gi] = slot_reg;
    end
  endgenerate

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
      break_reg   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg   <= count_next;
      overrun_reg <= push && !push_ok;
      break_reg   <= brk_det;
    end
  end

  assign head         = mem_rd[rd_ptr_reg];
  assign o_RX_Valid   = (count_reg != '0);
  assign o_RX_Data    = head[DATA_BITS-1:0];
  assign o_Frame_Err  = head[DATA_BITS];
  assign o_Parity_Err = head[DATA_BITS+1];
  assign o_Overrun    = overrun_reg;
  assign o_Break      = break_reg;
  assign o_Busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Two receivers share clock and reset: dut0 is 8N1, dut1 is 8E1, both with
//   16 clocks per bit and a 4-entry FIFO. Each sent frame is turned into an
//   expected FIFO entry (or break) due on a known cycle; a per-cycle process
//   keeps a queue model of each FIFO and compares every output to it.
//   Directed tests then pin that model with literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       line   [2];
  logic       ready  [2];
  logic       valid  [2];
  logic [7:0] data   [2];
  logic       perr_o [2];
  logic       ferr_o [2];
  logic       ovr_o  [2];
  logic       brk_o  [2];
  logic       busy_o [2];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[0]), .o_RX_Valid(valid[0]),
    .i_RX_Ready(ready[0]), .o_RX_Data(data[0]), .o_Parity_Err(perr_o[0]),
    .o_Frame_Err(ferr_o[0]), .o_Overrun(ovr_o[0]), .o_Break(brk_o[0]), .o_Busy(busy_o[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(line[1]), .o_RX_Valid(valid[1]),
    .i_RX_Ready(ready[1]), .o_RX_Data(data[1]), .o_Parity_Err(perr_o[1]),
    .o_Frame_Err(ferr_o[1]), .o_Overrun(ovr_o[1]), .o_Break(brk_o[1]), .o_Busy(busy_o[1]));

  typedef struct { int inst; int cyc; logic [9:0] ent; bit brk; } ev_t;
  typedef struct { int inst; int cyc; logic [7:0] data; logic perr; logic ferr; } beat_t;

  ev_t        evq [$];
  beat_t      got [$];
  beat_t      cmp_beat;
  logic [9:0] mf [2][DEPTH];
  int         mcnt [2];
  bit         pop_pend [2];
  bit         exp_ovr [2];
  bit         exp_brk [2];
  int         brk_seen [2];
  int         ovr_seen [2];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ------------------------------------------------ per-cycle model compare
  always @(negedge clk) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        mcnt[u]     = 0;
        pop_pend[u] = 1'b0;
      end
      evq.delete();
    end else begin
      for (int u = 0; u < 2; u++) begin
        exp_ovr[u] = 1'b0;
        exp_brk[u] = 1'b0;
        if (pop_pend[u]) begin
          for (int k = 0; k < DEPTH - 1; k++) mf[u][k] = mf[u][k+1];
          mcnt[u]--;
          pop_pend[u] = 1'b0;
        end
      end
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].cyc == cyc) begin
          if (evq[i].brk) exp_brk[evq[i].inst] = 1'b1;
          else if (mcnt[evq[i].inst] < DEPTH) begin
            mf[evq[i].inst][mcnt[evq[i].inst]] = evq[i].ent;
            mcnt[evq[i].inst]++;
          end else exp_ovr[evq[i].inst] = 1'b1;
          evq.delete(i);
        end
      end
      for (int u = 0; u < 2; u++) begin
        check($sformatf("valid%0d", u), valid[u], mcnt[u] != 0);
        if (mcnt[u] != 0) begin
          check($sformatf("data%0d", u), data[u], mf[u][0][7:0]);
          check($sformatf("frame_err%0d", u), ferr_o[u], mf[u][0][8]);
          check($sformatf("parity_err%0d", u), perr_o[u], mf[u][0][9]);
        end
        check($sformatf("overrun%0d", u), ovr_o[u], exp_ovr[u]);
        check($sformatf("break%0d", u), brk_o[u], exp_brk[u]);
        if (ovr_o[u]) ovr_seen[u]++;
        if (brk_o[u]) brk_seen[u]++;
        if (valid[u] && ready[u]) begin
          cmp_beat.inst = u;
          cmp_beat.cyc  = cyc;
          cmp_beat.data = data[u];
          cmp_beat.perr = perr_o[u];
          cmp_beat.ferr = ferr_o[u];
          got.push_back(cmp_beat);
        end
        pop_pend[u] = (mcnt[u] != 0) && ready[u];
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_line(int u, logic v, int n);
    line[u] = v;
    idle_cycles(n);
  endtask

  // Sends one frame (dut1 adds the given parity bit) and schedules its result.
  // Result is visible on cycle start + 2 (sync) + CPB*last_bit + MID+1 + 1.
  task automatic send_frame(int u, logic [7:0] d, logic p, logic stp);
    ev_t  ev;
    int   nb;
    int   ones;
    logic pe;
    nb      = (u == 1) ? 11 : 10;
    ones    = $countones({d, p});
    pe      = (u == 1) && (ones % 2 == 1);
    ev.inst = u;
    ev.cyc  = cyc + 2 + CPB * (nb - 1) + (CPB - 1) / 2 + 2;
    ev.brk  = (d == 8'h00) && (u == 0 || p == 1'b0) && (stp == 1'b0);
    ev.ent  = {pe, ~stp, d};
    evq.push_back(ev);
    $display("frame dut%0d data=0x%02h par=%0b stop=%0b expect perr=%0b ferr=%0b brk=%0b at cycle %0d",
             u, d, p, stp, pe, ~stp, ev.brk, ev.cyc);
    drive_line(u, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_line(u, d[i], CPB);
    if (u == 1) drive_line(u, p, CPB);
    drive_line(u, stp, CPB);
  endtask

  int s;

  initial begin
    rst = 1'b1;
    line[0] = 1'b1; line[1] = 1'b1;
    ready[0] = 1'b1; ready[1] = 1'b1;
    brk_seen[0] = 0; brk_seen[1] = 0;
    ovr_seen[0] = 0; ovr_seen[1] = 0;
    idle_cycles(3);
    check("rst_valid", valid[0], 0);
    check("rst_data", data[0], 0);
    check("rst_flags", {perr_o[0], ferr_o[0], ovr_o[0], brk_o[0]}, 0);
    check("rst_busy", {busy_o[0], busy_o[1]}, 0);
    rst = 1'b0;
    idle_cycles(4);

    // 8N1 0xA5: one clean beat, 2 + 9*16 + 8 = 154 cycles after the start
    // edge is the mid-stop commit, beat on the next cycle.
    got.delete();
    s = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    idle_cycles(CPB);
    check("a5_beats", got.size(), 1);
    if (got.size() > 0) begin
      check("a5_data", got[0].data, 8'hA5);
      check("a5_flags", {got[0].perr, got[0].ferr}, 0);
      check("a5_cycle", got[0].cyc, s + 155);
    end

    // 8E1 0x03 with parity 1 -> error, with parity 0 -> clean.
    got.delete();
    send_frame(1, 8'h03, 1'b1, 1'b1);
    idle_cycles(CPB);
    send_frame(1, 8'h03, 1'b0, 1'b1);
    idle_cycles(CPB);
    check("par_beats", got.size(), 2);
    if (got.size() == 2) begin
      check("par1_data", got[0].data, 8'h03);
      check("par1_perr", got[0].perr, 1);
      check("par0_perr", got[1].perr, 0);
    end

    // Framing error, line stays low 3 bit times, then a clean 0x12.
    got.delete();
    send_frame(0, 8'h55, 1'b0, 1'b0);
    drive_line(0, 1'b0, 3 * CPB);
    drive_line(0, 1'b1, 2 * CPB);
    send_frame(0, 8'h12, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check("ferr_beats", got.size(), 2);
    if (got.size() == 2) begin
      check("ferr_data", got[0].data, 8'h55);
      check("ferr_flag", got[0].ferr, 1);
      check("after_ferr_data", got[1].data, 8'h12);
      check("after_ferr_flags", {got[1].perr, got[1].ferr}, 0);
    end

    // Break: line low for 20 bit times.
    got.delete();
    brk_seen[0] = 0;
    send_frame(0, 8'h00, 1'b0, 1'b0);
    drive_line(0, 1'b0, 10 * CPB);
    drive_line(0, 1'b1, 2 * CPB);
    check("break_pulses", brk_seen[0], 1);
    check("break_beats", got.size(), 0);
    check("break_valid", valid[0], 0);

    // Overrun: 5 frames into a 4-deep FIFO with the consumer stalled.
    ready[0] = 1'b0;
    ovr_seen[0] = 0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i), 1'b0, 1'b1);
      idle_cycles(CPB);
    end
    check("ovr_pulses", ovr_seen[0], 1);
    check("ovr_head_valid", valid[0], 1);
    check("ovr_head_data", data[0], 8'h01);
    got.delete();
    ready[0] = 1'b1;
    idle_cycles(8);
    check("drain_beats", got.size(), 4);
    if (got.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("drain%0d_data", k), got[k].data, 8'(k + 1));
        check($sformatf("drain%0d_cycle", k), got[k].cyc - got[0].cyc, k);
      end
    end
    check("drain_valid", valid[0], 0);

    // 3-cycle low glitch on an idle line.
    got.delete();
    drive_line(0, 1'b0, 3);
    drive_line(0, 1'b1, 3 * CPB);
    check("glitch_beats", got.size(), 0);
    check("glitch_busy", busy_o[0], 0);

    // Reset during bit 4 of 0x3C (bits LSB first: 0,0,1,1,1,...).
    got.delete();
    drive_line(0, 1'b0, CPB);
    drive_line(0, 1'b0, CPB);
    drive_line(0, 1'b0, CPB);
    drive_line(0, 1'b1, CPB);
    drive_line(0, 1'b1, CPB);
    drive_line(0, 1'b1, CPB / 2);
    rst = 1'b1;
    idle_cycles(2);
    check("midrst_busy", busy_o[0], 0);
    check("midrst_valid", valid[0], 0);
    rst = 1'b0;
    idle_cycles(3 * CPB);
    check("midrst_beats", got.size(), 0);
    check("midrst_busy_after", busy_o[0], 0);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    idle_cycles(2 * CPB);
    check("post_rst_beats", got.size(), 1);
    if (got.size() == 1) check("post_rst_data", got[0].data, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
